// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT controller: FSM state encoding,
// transform size constants and the 3-bit bit-reversal helper.
package fft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_BUBBLE  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_agu.sv
// Butterfly address generator: maps (stage, butterfly n) to the operand
// indices and twiddle LUT address of a radix-2 DIT pass over 8 points.
module fft8_agu
  import fft8_pkg::*;
(
  input  logic [1:0] stage_i,
  input  logic [1:0] n_i,
  output logic [2:0] idx_a_o,
  output logic [2:0] idx_b_o,
  output logic [2:0] tw_o
);

  // Per-stage bit placement of j = n mod 2^s and g = n >> s
  always_comb begin
    idx_a_o = 3'd0;
    idx_b_o = 3'd0;
    tw_o    = 3'd0;
    case (stage_i)
      2'd0: begin
        idx_a_o = {n_i, 1'b0};
        idx_b_o = {n_i, 1'b1};
        tw_o    = 3'd0;
      end
      2'd1: begin
        idx_a_o = {n_i[1], 1'b0, n_i[0]};
        idx_b_o = {n_i[1], 1'b1, n_i[0]};
        tw_o    = {1'b0, n_i[0], 1'b0};
      end
      2'd2: begin
        idx_a_o = {1'b0, n_i};
        idx_b_o = {1'b1, n_i};
        tw_o    = {1'b0, n_i};
      end
      default: begin
        idx_a_o = 3'd0;
        idx_b_o = 3'd0;
        tw_o    = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/fft8_ctrl.sv
// Sequencer for an in-place 8-point radix-2 FFT: bit-reversed sample load,
// three butterfly stages with backpressure, and pipeline-drain bubbles.
module fft8_ctrl
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       in_valid,
  input  logic       bf_ready,
  output logic       load_we,
  output logic [2:0] load_addr,
  output logic       bf_valid,
  output logic [2:0] bf_idx_a,
  output logic [2:0] bf_idx_b,
  output logic [2:0] tw_addr,
  output logic [1:0] stage,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAT_LAST = 3'(BF_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] n_q, n_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] lat_q, lat_d;
  logic [2:0] agu_a_s, agu_b_s, agu_tw_s;

  fft8_agu u_agu (
    .stage_i (stage_q),
    .n_i     (n_q),
    .idx_a_o (agu_a_s),
    .idx_b_o (agu_b_s),
    .tw_o    (agu_tw_s)
  );

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    stage_d = stage_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_COMPUTE;
          else               state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_COMPUTE: begin
        if (bf_ready) begin
          n_d = n_q + 2'd1;
          // Last butterfly of the stage: drain the datapath or move straight on
          if (n_q == 2'd3) begin
            if (BF_LAT > 0) begin
              state_d = ST_BUBBLE;
              lat_d   = 3'd0;
            end else if (stage_q == 2'd2) begin
              state_d = ST_DONE;
            end else begin
              stage_d = stage_q + 2'd1;
            end
          end else begin
            state_d = ST_COMPUTE;
          end
        end else begin
          n_d = n_q;
        end
      end
      ST_BUBBLE: begin
        if (lat_q == LAT_LAST) begin
          lat_d = 3'd0;
          if (stage_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COMPUTE;
            stage_d = stage_q + 2'd1;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        n_d     = 2'd0;
        stage_d = 2'd0;
        lat_d   = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        n_d     = 2'd0;
        stage_d = 2'd0;
        lat_d   = 3'd0;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      n_q     <= 2'd0;
      stage_q <= 2'd0;
      lat_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      stage_q <= stage_d;
      lat_q   <= lat_d;
    end
  end

  // Output decode; everything is forced low while Reset is asserted
  always_comb begin
    load_we   = 1'b0;
    load_addr = 3'd0;
    bf_valid  = 1'b0;
    bf_idx_a  = 3'd0;
    bf_idx_b  = 3'd0;
    tw_addr   = 3'd0;
    stage     = 2'd0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!Reset) begin
      if (state_q == ST_LOAD) begin
        load_we   = in_valid;
        load_addr = bitrev3(cnt_q);
      end else begin
        load_we   = 1'b0;
        load_addr = 3'd0;
      end
      if (state_q == ST_COMPUTE) begin
        bf_valid = 1'b1;
        bf_idx_a = agu_a_s;
        bf_idx_b = agu_b_s;
        tw_addr  = agu_tw_s;
      end else begin
        bf_valid = 1'b0;
      end
      stage = stage_q;
      busy  = (state_q != ST_IDLE);
      done  = (state_q == ST_DONE);
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_fft8_ctrl.sv
// Directed, table-driven bench for fft8_ctrl: full run, backpressure, gapped
// input, mid-transform reset, held Start, plus a BF_LAT=0 instance.
module tb_fft8_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, in_valid, bf_ready;
  logic       load_we, bf_valid, busy, done;
  logic [2:0] load_addr, bf_idx_a, bf_idx_b, tw_addr;
  logic [1:0] stage;
  logic       z_load_we, z_bf_valid, z_busy, z_done;
  logic [2:0] z_load_addr, z_bf_idx_a, z_bf_idx_b, z_tw_addr;
  logic [1:0] z_stage;

  fft8_ctrl #(.BF_LAT(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .in_valid(in_valid), .bf_ready(bf_ready),
    .load_we(load_we), .load_addr(load_addr), .bf_valid(bf_valid), .bf_idx_a(bf_idx_a),
    .bf_idx_b(bf_idx_b), .tw_addr(tw_addr), .stage(stage), .busy(busy), .done(done)
  );

  fft8_ctrl #(.BF_LAT(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .in_valid(in_valid), .bf_ready(bf_ready),
    .load_we(z_load_we), .load_addr(z_load_addr), .bf_valid(z_bf_valid), .bf_idx_a(z_bf_idx_a),
    .bf_idx_b(z_bf_idx_b), .tw_addr(z_tw_addr), .stage(z_stage), .busy(z_busy), .done(z_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] st;
    logic [1:0] n;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
  } iss_vec_t;

  iss_vec_t   iss_tab [12];
  logic [2:0] lad [8];
  logic [2:0] rec_a [12], rec_b [12], rec_tw [12], rec_ld [8];
  logic [1:0] rec_st [12];
  int total = 0, bad = 0;
  int writes, issues, dones, zrun, gaps, excl, zfirst, zlast, zcnt, zdone, done_cyc;
  bit seen_issue;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // mode: 0 full, 1 backpressure, 2 gapped input, 3 reset mid-compute, 4 Start held
  task automatic run(input int mode);
    writes = 0; issues = 0; dones = 0; zrun = 0; gaps = 0; excl = 0;
    zfirst = -1; zlast = -1; zcnt = 0; zdone = -1; done_cyc = -1; seen_issue = 1'b0;
    Start = 1'b1; in_valid = 1'b0; bf_ready = 1'b1;
    tick();
    if (mode != 4) Start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      in_valid = (mode == 2) ? 1'(cyc % 2) : 1'b1;
      bf_ready = (mode == 1 && cyc >= 16 && cyc <= 18) ? 1'b0 : 1'b1;
      Reset    = (mode == 3 && cyc == 16) ? 1'b1 : 1'b0;
      #1;
      if (Reset)
        chk("outs_in_reset", {load_we, load_addr, bf_valid, bf_idx_a, bf_idx_b, tw_addr, stage, busy, done}, 32'd0);
      if (mode == 3 && cyc == 17)
        chk("outs_after_reset", {load_we, load_addr, bf_valid, bf_idx_a, bf_idx_b, tw_addr, stage, busy, done}, 32'd0);
      if (mode == 2 && !in_valid && writes > 0 && writes < 8) begin
        chk($sformatf("gap_we_c%0d", cyc), load_we, 1'b0);
        chk($sformatf("gap_addr_c%0d", cyc), load_addr, lad[writes]);
      end
      if (mode == 1 && cyc >= 16 && cyc <= 18)
        chk($sformatf("stall_hold_c%0d", cyc), {bf_valid, bf_idx_a, bf_idx_b, tw_addr, stage},
            {1'b1, 3'd1, 3'd3, 3'd2, 2'd1});
      if (load_we) begin
        if (writes < 8) rec_ld[writes] = load_addr;
        writes++;
      end
      if (bf_valid && bf_ready) begin
        if (issues < 12) begin
          rec_a[issues] = bf_idx_a; rec_b[issues] = bf_idx_b;
          rec_tw[issues] = tw_addr; rec_st[issues] = stage;
        end
        issues++;
        if (zrun > 0) begin
          gaps++;
          chk("bubble_len", zrun, 32'd2);
        end
        zrun = 0;
        seen_issue = 1'b1;
      end else if (!bf_valid && seen_issue && !done && !Reset) begin
        zrun++;
      end
      if (int'(load_we) + int'(bf_valid) + int'(done) > 1) excl++;
      if (z_bf_valid) begin
        if (zcnt == 0) zfirst = cyc;
        zlast = cyc;
        zcnt++;
      end
      if (z_done && zdone < 0) zdone = cyc;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (mode == 4 && cyc == 28) begin
        chk("held_start_idle_busy", busy, 1'b0);
        chk("held_start_idle_done", done, 1'b0);
      end
      if (mode == 4 && cyc == 29) begin
        chk("held_start_restart", {busy, load_we, load_addr}, {1'b1, 1'b1, 3'd0});
        break;
      end
      if (mode == 3 && cyc == 30) break;
      if (mode <= 2 && done) break;
      tick();
    end
    chk($sformatf("exclusive_m%0d", mode), excl, 32'd0);
  endtask

  task automatic post_idle(input int mode);
    Start = 1'b0;
    tick();
    chk($sformatf("idle_after_done_m%0d", mode), {busy, done, bf_valid, load_we}, 32'd0);
  endtask

  initial begin
    lad = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    iss_tab = '{
      '{2'd0, 2'd0, 3'd0, 3'd1, 3'd0}, '{2'd0, 2'd1, 3'd2, 3'd3, 3'd0},
      '{2'd0, 2'd2, 3'd4, 3'd5, 3'd0}, '{2'd0, 2'd3, 3'd6, 3'd7, 3'd0},
      '{2'd1, 2'd0, 3'd0, 3'd2, 3'd0}, '{2'd1, 2'd1, 3'd1, 3'd3, 3'd2},
      '{2'd1, 2'd2, 3'd4, 3'd6, 3'd0}, '{2'd1, 2'd3, 3'd5, 3'd7, 3'd2},
      '{2'd2, 2'd0, 3'd0, 3'd4, 3'd0}, '{2'd2, 2'd1, 3'd1, 3'd5, 3'd1},
      '{2'd2, 2'd2, 3'd2, 3'd6, 3'd2}, '{2'd2, 2'd3, 3'd3, 3'd7, 3'd3}
    };
    Reset = 1'b1; Start = 1'b1; in_valid = 1'b1; bf_ready = 1'b1;
    tick();
    tick();
    chk("reset_outs", {load_we, load_addr, bf_valid, bf_idx_a, bf_idx_b, tw_addr, stage, busy, done}, 32'd0);
    Reset = 1'b0; Start = 1'b0;
    tick();
    chk("idle_outs", {load_we, load_addr, bf_valid, bf_idx_a, bf_idx_b, tw_addr, stage, busy, done}, 32'd0);

    // Full run with the BF_LAT=0 instance checked alongside
    run(0);
    chk("full_done_cyc", done_cyc, 32'd27);
    chk("full_writes", writes, 32'd8);
    chk("full_issues", issues, 32'd12);
    chk("full_gaps", gaps, 32'd2);
    for (int i = 0; i < 8; i++)
      chk($sformatf("load_addr[%0d]", i), rec_ld[i], lad[i]);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("iss%0d_stage", i), rec_st[i], iss_tab[i].st);
      chk($sformatf("iss%0d_a", i), rec_a[i], iss_tab[i].a);
      chk($sformatf("iss%0d_b", i), rec_b[i], iss_tab[i].b);
      chk($sformatf("iss%0d_tw", i), rec_tw[i], iss_tab[i].tw);
    end
    chk("lat0_first_issue", zfirst, 32'd9);
    chk("lat0_last_issue", zlast, 32'd20);
    chk("lat0_issue_cycles", zcnt, 32'd12);
    chk("lat0_done_cyc", zdone, 32'd21);
    post_idle(0);

    run(1);
    chk("stall_done_cyc", done_cyc, 32'd30);
    chk("stall_issues", issues, 32'd12);
    post_idle(1);

    run(2);
    chk("gapped_writes", writes, 32'd8);
    chk("gapped_done_cyc", done_cyc, 32'd34);
    post_idle(2);

    run(3);
    chk("reset_mid_no_done", dones, 32'd0);
    chk("reset_mid_busy", busy, 1'b0);
    run(0);
    chk("after_reset_done_cyc", done_cyc, 32'd27);
    post_idle(3);

    run(4);
    chk("held_start_dones", dones, 32'd1);
    chk("held_start_done_cyc", done_cyc, 32'd27);
    Start = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("final_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
